// File: rtl/yuv420_unpack_if.sv
// Stream bundle for the YUV420 unpacker: beat input side, beat output side and the overrun flag.
// The master drives the input beat and enable; the slave (the unpacker) drives the output beat.
interface yuv420_unpack_if #(
    parameter int DTYPE_WIDTH = 4
);
    logic                   enable;
    logic                   dvi;
    logic [DTYPE_WIDTH-1:0] dtypei;
    logic [31:0]            datai;
    logic                   dvo;
    logic [DTYPE_WIDTH-1:0] dtypeo;
    logic [31:0]            datao;
    logic                   overrun;

    modport master (
        output enable, dvi, dtypei, datai,
        input  dvo, dtypeo, datao, overrun
    );

    modport slave (
        input  enable, dvi, dtypei, datai,
        output dvo, dtypeo, datao, overrun
    );
endinterface

// File: rtl/yuv420_unpack.sv
// Unpacks the YUV420 byte stream into {v,u,y1,y0} pixel pairs, replaying odd rows and a trailing even row.
// state      | meaning
// S_IDLE     | live path only; emits a pending FRAME_END
// S_ODD_*    | replay of the stored odd row (row start, words, row end)
// S_EVEN_*   | trailing even row with neutral chroma (row start, pairs, row end)
module yuv420_unpack #(
    parameter int MAX_COLS    = 1920,
    parameter int DTYPE_WIDTH = 4,
    parameter int EVEN_DEPTH  = MAX_COLS / 4,
    parameter int ODD_DEPTH   = MAX_COLS / 2
) (
    input  logic            clk,
    input  logic            reset,
    yuv420_unpack_if.slave  bus
);
    localparam logic [DTYPE_WIDTH-1:0] DT_FS = DTYPE_WIDTH'(1);
    localparam logic [DTYPE_WIDTH-1:0] DT_FE = DTYPE_WIDTH'(2);
    localparam logic [DTYPE_WIDTH-1:0] DT_RS = DTYPE_WIDTH'(3);
    localparam logic [DTYPE_WIDTH-1:0] DT_RE = DTYPE_WIDTH'(4);
    localparam logic [DTYPE_WIDTH-1:0] DT_PX = DTYPE_WIDTH'(5);

    localparam int CW  = $clog2(ODD_DEPTH + 1);
    localparam int OAW = $clog2(ODD_DEPTH);
    localparam int EAW = (EVEN_DEPTH > 1) ? $clog2(EVEN_DEPTH) : 1;
    localparam logic [CW-1:0] EVEN_LIM = CW'(EVEN_DEPTH);
    localparam logic [CW-1:0] ODD_LIM  = CW'(ODD_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ODD_RS, S_ODD_PIX, S_ODD_RE, S_EVEN_RS, S_EVEN_PIX, S_EVEN_RE
    } state_t;

    logic [31:0] r_even_buf [EVEN_DEPTH];
    logic [31:0] r_odd_buf  [ODD_DEPTH];

    logic                   r_dv1, r_en1, r_enabled, r_row_phase;
    logic [DTYPE_WIDTH-1:0] r_dt1;
    logic [31:0]            r_d1, r_fe_data;
    logic [CW-1:0]          r_col, r_even_words, r_odd_count, r_daddr, r_dleft;
    logic                   r_fe_pend, r_even_pend;
    state_t                 r_state;
    logic                   r_dvo, r_overrun;
    logic [DTYPE_WIDTH-1:0] r_dtypeo;
    logic [31:0]            r_datao;

    logic        w_live_emit, w_px_drop, w_ewr, w_owr;
    logic [31:0] w_live_data, w_ebuf_live, w_ebuf_drain, w_obuf_drain;

    assign w_ebuf_live  = r_even_buf[r_col[EAW:1]];
    assign w_ebuf_drain = r_even_buf[r_daddr[EAW:1]];
    assign w_obuf_drain = r_odd_buf[r_daddr[OAW-1:0]];

    always_comb begin
        w_live_emit = 1'b0;
        w_live_data = r_d1;
        w_ewr       = 1'b0;
        w_owr       = 1'b0;
        w_px_drop   = r_row_phase ? (r_col >= ODD_LIM) : (r_col >= EVEN_LIM);
        if (r_dv1 && r_enabled) begin
            case (r_dt1)
                DT_FS: begin
                    w_live_emit = 1'b0;
                end
                DT_RS, DT_RE: begin
                    w_live_emit = r_row_phase;
                end
                DT_PX: begin
                    if (r_row_phase) begin
                        w_live_emit = !w_px_drop;
                        w_owr       = !w_px_drop;
                        w_live_data = {r_d1[31:16], r_col[0] ? w_ebuf_live[31:16] : w_ebuf_live[15:0]};
                    end else begin
                        w_ewr = !w_px_drop;
                    end
                end
                // FRAME_END goes straight out only when nothing is queued ahead of it
                DT_FE: begin
                    w_live_emit = !r_row_phase && (r_state == S_IDLE) && !r_fe_pend && !r_even_pend;
                end
                default: begin
                    w_live_emit = (r_state == S_IDLE);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_ewr) r_even_buf[r_col[EAW-1:0]] <= r_d1;
        if (w_owr) r_odd_buf[r_col[OAW-1:0]] <= r_d1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dv1 <= 1'b0;  r_dt1 <= '0;  r_d1 <= '0;  r_en1 <= 1'b0;
            r_enabled <= 1'b0;  r_row_phase <= 1'b0;  r_col <= '0;
            r_even_words <= '0;  r_odd_count <= '0;  r_daddr <= '0;  r_dleft <= '0;
            r_fe_pend <= 1'b0;  r_even_pend <= 1'b0;  r_fe_data <= '0;
            r_state <= S_IDLE;
            r_dvo <= 1'b0;  r_dtypeo <= '0;  r_datao <= '0;  r_overrun <= 1'b0;
        end else begin
            r_dv1 <= bus.dvi;
            r_dt1 <= bus.dtypei;
            r_d1  <= bus.datai;
            r_en1 <= bus.enable;
            r_dvo <= 1'b0;
            if (r_dv1 && r_dt1 == DT_FS) begin
                r_enabled <= r_en1;  r_row_phase <= 1'b0;  r_col <= '0;
                r_even_words <= '0;  r_odd_count <= '0;  r_daddr <= '0;  r_dleft <= '0;
                r_fe_pend <= 1'b0;  r_even_pend <= 1'b0;  r_state <= S_IDLE;
                r_overrun <= 1'b0;
                r_dvo <= 1'b1;  r_dtypeo <= r_dt1;  r_datao <= r_d1;
            end else if (!r_enabled) begin
                if (r_dv1) begin
                    r_dvo <= 1'b1;  r_dtypeo <= r_dt1;  r_datao <= r_d1;
                end
            end else begin
                // a live beat owns the output; any drain in progress simply waits a clock
                if (w_live_emit) begin
                    r_dvo <= 1'b1;  r_dtypeo <= r_dt1;  r_datao <= w_live_data;
                    if (r_state != S_IDLE) r_overrun <= 1'b1;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (r_even_pend) begin
                                r_even_pend <= 1'b0;
                                r_state     <= S_EVEN_RS;
                            end else if (r_fe_pend) begin
                                r_fe_pend <= 1'b0;
                                r_dvo <= 1'b1;  r_dtypeo <= DT_FE;  r_datao <= r_fe_data;
                            end
                        end
                        S_ODD_RS: begin
                            r_dvo <= 1'b1;  r_dtypeo <= DT_RS;  r_datao <= '0;
                            r_daddr <= '0;
                            r_dleft <= r_odd_count;
                            r_state <= (r_odd_count != '0) ? S_ODD_PIX : S_ODD_RE;
                        end
                        S_ODD_PIX: begin
                            r_dvo <= 1'b1;  r_dtypeo <= DT_PX;  r_datao <= w_obuf_drain;
                            r_daddr <= r_daddr + 1'b1;
                            r_dleft <= r_dleft - 1'b1;
                            if (r_dleft == CW'(1)) r_state <= S_ODD_RE;
                        end
                        S_EVEN_RS: begin
                            r_dvo <= 1'b1;  r_dtypeo <= DT_RS;  r_datao <= '0;
                            r_daddr <= '0;
                            r_dleft <= {r_even_words[CW-2:0], 1'b0};
                            r_state <= (r_even_words != '0) ? S_EVEN_PIX : S_EVEN_RE;
                        end
                        S_EVEN_PIX: begin
                            r_dvo <= 1'b1;  r_dtypeo <= DT_PX;
                            r_datao <= {16'h8080, r_daddr[0] ? w_ebuf_drain[31:16] : w_ebuf_drain[15:0]};
                            r_daddr <= r_daddr + 1'b1;
                            r_dleft <= r_dleft - 1'b1;
                            if (r_dleft == CW'(1)) r_state <= S_EVEN_RE;
                        end
                        default: begin
                            r_dvo <= 1'b1;  r_dtypeo <= DT_RE;  r_datao <= '0;
                            r_state <= S_IDLE;
                        end
                    endcase
                end
                if (r_dv1) begin
                    case (r_dt1)
                        DT_RS: r_col <= '0;
                        DT_RE: begin
                            r_row_phase <= ~r_row_phase;
                            r_col       <= '0;
                            if (!r_row_phase) begin
                                r_even_words <= (r_col > EVEN_LIM) ? EVEN_LIM : r_col;
                            end else begin
                                r_odd_count <= (r_col > ODD_LIM) ? ODD_LIM : r_col;
                                r_state     <= S_ODD_RS;
                            end
                        end
                        DT_PX: begin
                            if (r_col != '1) r_col <= r_col + 1'b1;
                            if (w_px_drop) r_overrun <= 1'b1;
                        end
                        DT_FE: begin
                            r_fe_data <= r_d1;
                            if (r_row_phase) begin
                                if (r_state == S_IDLE && !r_fe_pend && !r_even_pend) r_state <= S_EVEN_RS;
                                else r_even_pend <= 1'b1;
                            end
                            if (!w_live_emit) r_fe_pend <= 1'b1;
                        end
                        default: begin
                            if (r_state != S_IDLE) r_overrun <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.dvo     = r_dvo;
    assign bus.dtypeo  = r_dtypeo;
    assign bus.datao   = r_datao;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_yuv420_unpack.sv
// Directed bench for yuv420_unpack: cycle-exact vector table plus stream-capture sequences.
// Table rows hold the output expected after that row's clock edge (i.e. the result of the previous row's input).
module tb_yuv420_unpack;
    localparam logic [3:0] FS = 4'd1, FE = 4'd2, RS = 4'd3, RE = 4'd4, PX = 4'd5, HD = 4'd7;

    logic clk, reset;
    yuv420_unpack_if #(.DTYPE_WIDTH(4)) bus();

    yuv420_unpack #(.MAX_COLS(1920), .DTYPE_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        dv;
        logic [3:0]  dt;
        logic [31:0] d;
        logic        edv;
        logic [3:0]  edt;
        logic [31:0] ed;
    } vec_t;

    typedef struct {
        logic [3:0]  dt;
        logic [31:0] d;
    } beat_t;

    vec_t  tbl [36];
    beat_t cap [$];
    beat_t expq [$];
    bit    cap_en;
    int    n_checks, n_fail;

    always @(negedge clk) begin
        if (cap_en && bus.dvo) cap.push_back('{bus.dtypeo, bus.datao});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic setv(input int i, input logic en, input logic dv, input logic [3:0] dt, input logic [31:0] d,
                        input logic edv, input logic [3:0] edt, input logic [31:0] ed);
        tbl[i] = '{en, dv, dt, d, edv, edt, ed};
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.dvi = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [3:0] dt, input logic [31:0] d);
        bus.dvi = 1'b1;  bus.dtypei = dt;  bus.datai = d;
        tick();
        bus.dvi = 1'b0;
        tick();
    endtask

    task automatic send_fs(input logic en);
        bus.enable = en;
        send(FS, 32'h0);
    endtask

    task automatic send_first_rows();
        send(RS, 0);  send(PX, 32'h03020100);  send(PX, 32'h07060504);  send(RE, 0);
        send(RS, 0);  send(PX, 32'h80401110);  send(PX, 32'h81411312);
        send(PX, 32'h82421514);  send(PX, 32'h83431716);  send(RE, 0);
    endtask

    task automatic run_tbl(input int lo, input int hi);
        logic [63:0] act, req;
        for (int i = lo; i <= hi; i++) begin
            bus.enable = tbl[i].en;  bus.dvi = tbl[i].dv;
            bus.dtypei = tbl[i].dt;  bus.datai = tbl[i].d;
            tick();
            req = {26'h0, 1'b0, tbl[i].edv, tbl[i].edv ? {tbl[i].edt, tbl[i].ed} : 36'h0};
            act = {26'h0, bus.overrun, bus.dvo, tbl[i].edv ? {bus.dtypeo, bus.datao} : 36'h0};
            chk($sformatf("tbl[%0d]", i), act, req);
        end
        bus.dvi = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] dt, input logic [31:0] d);
        expq.push_back('{dt, d});
    endtask

    task automatic push_first_rows_exp();
        push_exp(FS, 0);  push_exp(RS, 0);
        push_exp(PX, 32'h80400100);  push_exp(PX, 32'h81410302);
        push_exp(PX, 32'h82420504);  push_exp(PX, 32'h83430706);  push_exp(RE, 0);
        push_exp(RS, 0);
        push_exp(PX, 32'h80401110);  push_exp(PX, 32'h81411312);
        push_exp(PX, 32'h82421514);  push_exp(PX, 32'h83431716);  push_exp(RE, 0);
    endtask

    task automatic cmp_stream(input string nm);
        chk({nm, "_len"}, 64'(cap.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < cap.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), {28'h0, cap[i].dt, cap[i].d}, {28'h0, expq[i].dt, expq[i].d});
    endtask

    initial begin
        n_checks = 0;  n_fail = 0;  cap_en = 1'b0;
        // odd/even frame, width 8
        setv(0, 1, 1, FS, 0, 0, 0, 0);
        setv(1, 1, 1, RS, 0, 1, FS, 0);
        setv(2, 1, 1, PX, 32'h03020100, 0, 0, 0);
        setv(3, 1, 0, 0, 0, 0, 0, 0);
        setv(4, 1, 1, PX, 32'h07060504, 0, 0, 0);
        setv(5, 1, 0, 0, 0, 0, 0, 0);
        setv(6, 1, 1, RE, 0, 0, 0, 0);
        setv(7, 1, 1, RS, 0, 0, 0, 0);
        setv(8, 1, 1, PX, 32'h80401110, 1, RS, 0);
        setv(9, 1, 0, 0, 0, 1, PX, 32'h80400100);
        setv(10, 1, 1, PX, 32'h81411312, 0, 0, 0);
        setv(11, 1, 0, 0, 0, 1, PX, 32'h81410302);
        setv(12, 1, 1, PX, 32'h82421514, 0, 0, 0);
        setv(13, 1, 0, 0, 0, 1, PX, 32'h82420504);
        setv(14, 1, 1, PX, 32'h83431716, 0, 0, 0);
        setv(15, 1, 0, 0, 0, 1, PX, 32'h83430706);
        setv(16, 1, 1, RE, 0, 0, 0, 0);
        setv(17, 1, 0, 0, 0, 1, RE, 0);
        setv(18, 1, 0, 0, 0, 1, RS, 0);
        setv(19, 1, 0, 0, 0, 1, PX, 32'h80401110);
        setv(20, 1, 1, FE, 0, 1, PX, 32'h81411312);
        setv(21, 1, 0, 0, 0, 1, PX, 32'h82421514);
        setv(22, 1, 0, 0, 0, 1, PX, 32'h83431716);
        setv(23, 1, 0, 0, 0, 1, RE, 0);
        setv(24, 1, 0, 0, 0, 1, FE, 0);
        setv(25, 1, 0, 0, 0, 0, 0, 0);
        // bypass, back-to-back beats
        setv(26, 0, 1, FS, 0, 0, 0, 0);
        setv(27, 0, 1, HD, 32'h11111111, 1, FS, 0);
        setv(28, 0, 1, PX, 32'hAABBCCDD, 1, HD, 32'h11111111);
        setv(29, 0, 1, PX, 32'h01234567, 1, PX, 32'hAABBCCDD);
        setv(30, 0, 1, RS, 0, 1, PX, 32'h01234567);
        setv(31, 0, 1, RE, 32'hDEADBEEF, 1, RS, 0);
        setv(32, 0, 0, 0, 0, 1, RE, 32'hDEADBEEF);
        setv(33, 0, 1, FE, 0, 0, 0, 0);
        setv(34, 0, 0, 0, 0, 1, FE, 0);
        setv(35, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1;  bus.enable = 1'b0;  bus.dvi = 1'b0;  bus.dtypei = '0;  bus.datai = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {26'h0, bus.overrun, bus.dvo, bus.dtypeo, bus.datao}, 64'h0);
        reset = 1'b0;

        run_tbl(0, 25);
        run_tbl(26, 35);

        // three-row frame: trailing even row drained with neutral chroma, then FRAME_END
        cap.delete();  expq.delete();  cap_en = 1'b1;
        send_fs(1);
        send_first_rows();
        idle(10);
        send(RS, 0);  send(PX, 32'h0B0A0908);  send(PX, 32'h0F0E0D0C);  send(RE, 0);
        send(FE, 0);
        idle(12);
        cap_en = 1'b0;
        push_first_rows_exp();
        push_exp(RS, 0);
        push_exp(PX, 32'h80800908);  push_exp(PX, 32'h80800B0A);
        push_exp(PX, 32'h80800D0C);  push_exp(PX, 32'h80800F0E);
        push_exp(RE, 0);  push_exp(FE, 0);
        cmp_stream("three_row");

        // HEADER during odd-row drain is dropped and flags overrun until the next FRAME_START
        cap.delete();  expq.delete();  cap_en = 1'b1;
        send_fs(1);
        send_first_rows();
        send(HD, 32'h12345678);
        idle(10);
        cap_en = 1'b0;
        push_first_rows_exp();
        cmp_stream("hdr_drop");
        chk("hdr_overrun_set", 64'(bus.overrun), 64'd1);
        send_fs(1);
        idle(1);
        chk("hdr_overrun_clear", 64'(bus.overrun), 64'd0);

        // even row one word beyond the buffer
        send_fs(1);
        send(RS, 0);
        for (int k = 0; k < 480; k++) send(PX, {k[15:0], k[15:0]});
        idle(2);
        chk("even480_no_overrun", 64'(bus.overrun), 64'd0);
        send(PX, 32'hFFFFFFFF);
        idle(2);
        chk("even481_overrun", 64'(bus.overrun), 64'd1);
        send(RE, 0);
        cap.delete();  cap_en = 1'b1;
        send(FE, 0);
        idle(970);
        cap_en = 1'b0;
        chk("even481_len", 64'(cap.size()), 64'd963);
        if (cap.size() == 963) begin
            chk("even481_rs", {28'h0, cap[0].dt, cap[0].d}, {28'h0, RS, 32'h0});
            chk("even481_first", {28'h0, cap[1].dt, cap[1].d}, {28'h0, PX, 32'h80800000});
            chk("even481_last", {28'h0, cap[960].dt, cap[960].d}, {28'h0, PX, 32'h808001DF});
            chk("even481_fe", {28'h0, cap[962].dt, cap[962].d}, {28'h0, FE, 32'h0});
        end

        // reset in the middle of an odd-row drain, then a clean frame
        send_fs(1);
        send_first_rows();
        reset = 1'b1;
        tick();
        chk("mid_reset_out", {26'h0, bus.overrun, bus.dvo, bus.dtypeo, bus.datao}, 64'h0);
        reset = 1'b0;
        begin
            int seen = 0;
            repeat (4) begin
                tick();
                if (bus.dvo) seen++;
            end
            chk("mid_reset_quiet", 64'(seen), 64'd0);
        end
        run_tbl(0, 25);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/yuv420_unpack.md
Name: yuv420_unpack

Overview:
- Decoder for the packed YUV420 byte stream produced by the team's YUV420 packer.
- Reconstructs horizontal pixel pairs, each carrying two luma samples and a shared chroma pair, with chroma upsampled vertically across each even/odd row pair.
- Sits after the SRAM/USB readback path and ahead of display or colour-conversion blocks on the standard dvi/dtype/data stream.

Parameters:
- MAX_COLS, 1920, maximum image width in pixels; must be a multiple of 4.
- EVEN_DEPTH, MAX_COLS/4, even-row luma buffer depth in 32b words.
- ODD_DEPTH, MAX_COLS/2, odd-row pair buffer depth in 32b words.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- enable  in  1  0 = bypass; sampled only on FRAME_START.
- dvi  in  1  input beat valid.
- dtypei  in  DTYPE_WIDTH  input beat type.
- datai  in  32  packed bytes; byte0 = datai[7:0] is the earliest byte.
- dvo  out  1  output beat valid.
- dtypeo  out  DTYPE_WIDTH  output beat type.
- datao  out  32  {v,u,y1,y0}; y0 is the left pixel. Non-pixel beats forward datai.
- overrun  out  1  sticky protocol-error flag; cleared by reset or FRAME_START.

Behaviour:
- Reset: dvo=0, dtypeo=0, datao=0, overrun=0, FSM=IDLE, row_phase=0, all counters 0. Reset mid-frame discards all buffered data.
- Upstream guarantees:
  - Image width is a multiple of 4, so every row starts word-aligned.
  - Even row = cols/4 words of 4 luma bytes.
  - Odd row = cols/2 words, each {v,u,y1,y0}.
  - Pixel beats are separated by at least 1 idle clock.
- Bypass (enable latched 0): each input beat is registered straight through with 2-clock latency. No buffering; overrun stays 0.
- row_phase:
  - Cleared on FRAME_START.
  - Toggled on each input ROW_END.
- Even row (row_phase=0):
  - Pixel word k is written to even_buf[k].
  - Writes with k >= EVEN_DEPTH are dropped and set overrun.
  - ROW_START and ROW_END are consumed; nothing is emitted.
- Odd row (row_phase=1), live path, latency 2 clocks:
  - Input ROW_START -> output ROW_START.
  - Pixel word j -> odd_buf[j] <= datai, and one output PIXEL beat {datai[31:16], Y}. Y = even_buf[j>>1][15:0] if j is even, else [31:16].
  - Input ROW_END -> output ROW_END; latch odd_count = j; enter DRAIN_ODD.
- DRAIN_ODD sequence, one item per clock:
  - ROW_START.
  - odd_buf[0..odd_count-1] as PIXEL beats, datao = stored word unchanged.
  - ROW_END.
  - Then go to IDLE.
  - The first drain item appears 1 clock after the live ROW_END.
  - New even-row writes proceed concurrently.
- FRAME_END:
  - If row_phase=1 (odd row count), enter DRAIN_EVEN: ROW_START, then cols/2 pairs taken from even_buf with u=v=8'h80, then ROW_END.
  - pair count = 2*even_words, where even_words is the number of words in the last even row.
  - FRAME_END is held pending until any drain completes, then emitted on the next clock.
- Other dtypes (HEADER_START, HEADER, ...):
  - Forwarded unchanged with 2-clock latency when FSM=IDLE.
  - If they arrive during DRAIN_*, they are dropped and overrun is set.
- Collisions:
  - A live odd-row pixel arriving during a drain sets overrun.
  - In that case the live beat wins the output and the drain stalls for one clock.
- FRAME_START:
  - Aborts any drain and clears counters and row_phase.
  - Latches enable.
  - Is forwarded with 2-clock latency.
- Output beats are never dropped while overrun=0.

Test Plan:
- Even row 0x03020100, 0x07060504; odd row 0x80401110, 0x81411312, 0x82421514, 0x83431716.
  - -> Live: ROW_START, then 0x80400100, 0x81410302, 0x82420504, 0x83430706, then ROW_END.
  - -> Drain: ROW_START, the four odd words unchanged, ROW_END.
  - -> Then FRAME_END.
- Frame with 3 rows, width 8, third row 0x0B0A0908, 0x0F0E0D0C.
  - -> After FRAME_END input, output ROW_START, 0x80800908, 0x80800B0A, 0x80800D0C, 0x80800F0E, ROW_END, then FRAME_END.
- enable=0 at FRAME_START, arbitrary beats.
  - -> Identical stream 2 clocks later; overrun=0.
- HEADER beat injected during DRAIN_ODD.
  - -> Beat dropped, overrun=1; overrun clears at the next FRAME_START.
- Even row of 481 words with MAX_COLS=1920.
  - -> Word 480 not stored; overrun=1.
- reset asserted mid-drain, then a full width-8 frame.
  - -> dvo=0 the clock after reset; the following frame matches scenario 1 exactly.
